// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped read cache: tag lookup, hit-word select,
// line refill from main memory on a miss, and saturating hit/access counters.
module cache_controller #(
   parameter int TAG_W    = 3,
   parameter int INDEX_W  = 10,
   parameter int OFFSET_W = 2,
   parameter int WORD_W   = 32,
   parameter int CNT_W    = 14
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cpu_read,
   input  logic [TAG_W+INDEX_W+OFFSET_W-1:0]     cpu_address,
   output logic                                  cpu_ready,
   output logic [WORD_W-1:0]                     cpu_data,
   output logic                                  hit,
   output logic [INDEX_W-1:0]                    arr_index,
   input  logic [TAG_W-1:0]                      arr_tag_in,
   input  logic                                  arr_valid_in,
   input  logic [WORD_W*(2**OFFSET_W)-1:0]       arr_line_in,
   output logic                                  arr_write,
   output logic [TAG_W-1:0]                      arr_tag_out,
   output logic [WORD_W*(2**OFFSET_W)-1:0]       arr_line_out,
   output logic                                  mem_read,
   output logic [TAG_W+INDEX_W-1:0]              mem_address,
   input  logic                                  mem_ready,
   input  logic [WORD_W*(2**OFFSET_W)-1:0]       mem_line,
   output logic [CNT_W-1:0]                      hit_count,
   output logic [CNT_W-1:0]                      access_count
);

   localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
   localparam int LINE_W = WORD_W * (2**OFFSET_W);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS_WAIT, S_RESPOND} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                cpu_ready_q, cpu_ready_d;
   logic                hit_q, hit_d;
   logic [WORD_W-1:0]   cpu_data_q, cpu_data_d;
   logic                arr_write_q, arr_write_d;
   logic [TAG_W-1:0]    arr_tag_out_q, arr_tag_out_d;
   logic [LINE_W-1:0]   arr_line_out_q, arr_line_out_d;
   logic                mem_read_q, mem_read_d;
   logic [TAG_W+INDEX_W-1:0] mem_address_q, mem_address_d;
   logic [CNT_W-1:0]    hit_count_q, hit_count_d;
   logic [CNT_W-1:0]    access_count_q, access_count_d;

   logic [TAG_W-1:0]    tag_l;
   logic [INDEX_W-1:0]  index_l;
   logic [OFFSET_W-1:0] off_l;
   logic                accept, lookup_hit;

   assign tag_l      = addr_q[ADDR_W-1 -: TAG_W];
   assign index_l    = addr_q[OFFSET_W +: INDEX_W];
   assign off_l      = addr_q[OFFSET_W-1:0];
   assign accept     = (state_q == S_IDLE) && cpu_read && !rst;
   assign lookup_hit = arr_valid_in && (arr_tag_in == tag_l);

   // The array has one cycle of read latency, so the index bypasses the
   // address latch on accept; tag/line then arrive during LOOKUP.
   assign arr_index = accept ? cpu_address[OFFSET_W +: INDEX_W] : index_l;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      cpu_ready_d    = 1'b0;
      hit_d          = 1'b0;
      arr_write_d    = 1'b0;
      cpu_data_d     = cpu_data_q;
      arr_tag_out_d  = arr_tag_out_q;
      arr_line_out_d = arr_line_out_q;
      mem_read_d     = mem_read_q;
      mem_address_d  = mem_address_q;
      hit_count_d    = hit_count_q;
      access_count_d = access_count_q;
      case (state_q)
         S_IDLE: begin
            if (cpu_read) begin
               addr_d  = cpu_address;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (access_count_q != CNT_MAX) access_count_d = access_count_q + 1'b1;
            if (lookup_hit) begin
               if (hit_count_q != CNT_MAX) hit_count_d = hit_count_q + 1'b1;
               cpu_data_d  = arr_line_in[off_l*WORD_W +: WORD_W];
               hit_d       = 1'b1;
               cpu_ready_d = 1'b1;
               state_d     = S_RESPOND;
            end else begin
               mem_read_d    = 1'b1;
               mem_address_d = {tag_l, index_l};
               state_d       = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            if (mem_ready) begin
               mem_read_d     = 1'b0;
               arr_write_d    = 1'b1;
               arr_tag_out_d  = tag_l;
               arr_line_out_d = mem_line;
               cpu_data_d     = mem_line[off_l*WORD_W +: WORD_W];
               cpu_ready_d    = 1'b1;
               state_d        = S_RESPOND;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         cpu_ready_q    <= 1'b0;
         hit_q          <= 1'b0;
         cpu_data_q     <= '0;
         arr_write_q    <= 1'b0;
         arr_tag_out_q  <= '0;
         arr_line_out_q <= '0;
         mem_read_q     <= 1'b0;
         mem_address_q  <= '0;
         hit_count_q    <= '0;
         access_count_q <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         cpu_ready_q    <= cpu_ready_d;
         hit_q          <= hit_d;
         cpu_data_q     <= cpu_data_d;
         arr_write_q    <= arr_write_d;
         arr_tag_out_q  <= arr_tag_out_d;
         arr_line_out_q <= arr_line_out_d;
         mem_read_q     <= mem_read_d;
         mem_address_q  <= mem_address_d;
         hit_count_q    <= hit_count_d;
         access_count_q <= access_count_d;
      end
   end

   assign cpu_ready    = cpu_ready_q;
   assign hit          = hit_q;
   assign cpu_data     = cpu_data_q;
   assign arr_write    = arr_write_q;
   assign arr_tag_out  = arr_tag_out_q;
   assign arr_line_out = arr_line_out_q;
   assign mem_read     = mem_read_q;
   assign mem_address  = mem_address_q;
   assign hit_count    = hit_count_q;
   assign access_count = access_count_q;

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for the direct-mapped read cache: 1024 blocks × 4 words × 32 bits, 3-bit tag, valid bit per block, 15-bit word address. Sits between the CPU request port, the cache storage array and main memory. Performs the tag lookup and selects the hit word. On a miss it fetches the full 4-word line from main memory, writes the line into the array, and returns the requested word. Keeps the hit and access counters used for hit-rate reporting.

## Interface
Parameters:
- TAG_W, 3, tag width (address bits [14:12])
- INDEX_W, 10, block index width (address bits [11:2])
- OFFSET_W, 2, word offset width (address bits [1:0])
- WORD_W, 32, data word width
- CNT_W, 14, counter width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_read  in  1  request strobe; sampled only in IDLE
- cpu_address  in  15  word address; CPU holds it stable until cpu_ready
- cpu_ready  out  1  one-cycle pulse; cpu_data valid in the same cycle
- cpu_data  out  32  returned word, registered
- hit  out  1  one-cycle pulse in the RESPOND cycle when the access hit
- arr_index  out  10  array read/write index
- arr_tag_in  in  3  stored tag, valid 1 cycle after arr_index
- arr_valid_in  in  1  stored valid bit, same timing
- arr_line_in  in  128  stored line, same timing; word w = bits [32w+31:32w]
- arr_write  out  1  one-cycle write strobe: line, tag, valid=1
- arr_tag_out  out  3  tag to write
- arr_line_out  out  128  line to write
- mem_read  out  1  line fetch request, level
- mem_address  out  13  block address {tag, index}
- mem_ready  in  1  one-cycle pulse; mem_line valid in the same cycle
- mem_line  in  128  fetched line
- hit_count  out  14  number of hits, saturating
- access_count  out  14  number of lookups, saturating

## Operation
- States: IDLE, LOOKUP, MISS_WAIT, RESPOND.
- IDLE
  - When cpu_read=1: latch cpu_address, drive arr_index = address[11:2], go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP
  - Increment access_count.
  - Hit = arr_valid_in & (arr_tag_in == latched tag).
  - On hit: increment hit_count, register the selected word of arr_line_in into cpu_data, set the hit flag, go to RESPOND.
  - On miss: go to MISS_WAIT.
- MISS_WAIT
  - mem_read=1 and mem_address={tag, index} held steady until mem_ready.
  - On mem_ready:
    - Pulse arr_write with arr_line_out=mem_line, arr_tag_out=latched tag, arr_index=latched index.
    - Register the offset-selected word of mem_line into cpu_data.
    - Go to RESPOND.
  - mem_read drops in the cycle after mem_ready.
- RESPOND: cpu_ready=1; hit=1 only if the access hit; go to IDLE.
- Counters saturate at 16383 and do not wrap. Once access_count saturates, hit_count may still increment until it also saturates.
- cpu_read outside IDLE is ignored. There is no queueing.
- mem_ready outside MISS_WAIT is ignored. It causes no array write.
- Reset, including in the middle of an operation:
  - Synchronous; the state returns to IDLE on the next edge.
  - An in-flight fill is abandoned with no arr_write.
  - The latched request is discarded.

## Timing
- Reset values: cpu_ready=0, hit=0, cpu_data=0, arr_write=0, arr_tag_out=0, arr_line_out=0, arr_index=0, mem_read=0, mem_address=0, hit_count=0, access_count=0.
- Hit latency: cpu_read sampled at edge T; LOOKUP at T+1; cpu_ready high in cycle T+2.
- Miss latency: mem_read rises in the cycle after LOOKUP; cpu_ready is high in the cycle after mem_ready.
- Back-to-back: the next cpu_read is sampled in the IDLE cycle after RESPOND. The minimum hit-to-hit spacing is 3 cycles.
- A line write in cycle N is visible to a lookup issued in cycle N+2 or later.

## Test plan
- Reset then idle: after rst is held high for 2 cycles, every output is 0 and no cpu_ready appears for 10 cycles.
- Cold miss at address 0x1234 (tag 1, index 0x08D, offset 0), with mem_ready 5 cycles after mem_read and mem_line word0 = 0xCAFEF00D:
  - mem_address = 0x048D.
  - Exactly one arr_write, with tag 1 and index 0x08D.
  - cpu_data = 0xCAFEF00D; hit = 0.
  - access_count = 1, hit_count = 0.
- Follow-up read at 0x1237 (same block, offset 3): cpu_ready at T+2, hit = 1, cpu_data = word3 of the stored line, no mem_read, hit_count = 1.
- Conflict miss at 0x5234 (tag 5, same index): mem_read asserted and the line refilled with tag 5. A following read at 0x1234 misses again.
- Spurious mem_ready while in IDLE, and cpu_read pulses during MISS_WAIT: no arr_write, no extra access_count increment, exactly one cpu_ready.
- rst asserted during MISS_WAIT, then mem_ready arrives: no arr_write, state is IDLE, counters are 0.
- 16400 hits to the same address: hit_count and access_count stop at 16383.
